serial_sub16: RTL

- Multi-cycle, nibble-serial subtractor for operands wider than 4 bits.
- Latches two W-bit operands and an incoming borrow.
- Subtracts one 4-bit nibble per clock, LSB nibble first, chaining the borrow between nibbles.
- Assembles the W-bit difference and final borrow, then reports completion with a one-cycle done pulse.
- Sits between the operand source (register file or controller) and the result consumer. Lets a single 4-bit subtract datapath serve 16-bit arithmetic.

---
 rtl/serial_sub16.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_sub16.sv
// ---------------------------------------------------------------------------
// serial_sub16
//   Nibble-serial subtractor. Latches two W-bit operands (W = 4*NIBBLES) and a
//   borrow-in on an accepted start, then runs one 4-bit subtract per clock,
//   LSB nibble first, chaining the borrow between nibbles. When the top nibble
//   has been processed, the full difference and final borrow are presented
//   with a one-cycle done pulse.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   i_start  in   1  begin a subtraction (sampled only in IDLE)
//   i_a      in   W  minuend, latched on accepted start
//   i_b      in   W  subtrahend, latched on accepted start
//   i_bin    in   1  borrow-in, latched on accepted start
//   o_busy   out  1  high while nibbles are being processed
//   o_done   out  1  one-cycle pulse when o_d / o_bout are final
//   o_d      out  W  a - b - bin modulo 2^W (partial nibbles visible in RUN)
//   o_bout   out  1  1 iff a < b + bin (unsigned)
// ---------------------------------------------------------------------------
module serial_sub16 #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [4*NIBBLES-1:0] i_a,
    input  logic [4*NIBBLES-1:0] i_b,
    input  logic                 i_bin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [4*NIBBLES-1:0] o_d,
    output logic                 o_bout
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One nibble of subtraction: bit 4 of the result is the borrow out.
    function automatic logic [4:0] sub_nibble(input logic [3:0] a_nib,
                                              input logic [3:0] b_nib,
                                              input logic       brw);
        sub_nibble = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, brw};
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_d;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;

    logic [4:0]       w_diff;
    logic [W-1:0]     w_d_next;
    logic             w_last;

    // Operands shift right each nibble, so the active nibble is always [3:0].
    assign w_diff = sub_nibble(r_a[3:0], r_b[3:0], r_borrow);
    assign w_last = (r_cnt == CNT_W'(NIBBLES - 1));

    always_comb begin
        w_d_next = r_d;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_d_next[4*k +: 4] = w_diff[3:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_RUN;
            S_RUN:   if (w_last)  w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Status flags decoded from the next state keep them as clean flops.
            r_busy  <= (w_next_state == S_RUN);
            r_done  <= (w_next_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_borrow <= i_bin;
                        r_cnt    <= '0;
                        r_d      <= '0;
                    end
                end
                S_RUN: begin
                    r_a      <= {4'b0000, r_a[W-1:4]};
                    r_b      <= {4'b0000, r_b[W-1:4]};
                    r_borrow <= w_diff[4];
                    r_d      <= w_d_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bout <= w_diff[4];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_d    = r_d;
    assign o_bout = r_bout;

endmodule
